udp_rx_checker: RTL



---
 rtl/udp_test_pkg.sv | 21 ++
 rtl/lfsr16.sv | 23 ++
 rtl/udp_rx_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/udp_test_pkg.sv
// Shared types and constants for the UDP receive-side pattern checker.
// The LFSR constants matter only when UDP_RX_CHECKER_STALL_EN is defined.
package udp_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BAD
    } chk_state_t;

    localparam int unsigned CNT_W = 11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes only its output bit.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'h002D
) (
    input  logic clk,
    input  logic rst_n,
    output logic lsb
);

    logic [15:0] state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {^(state & TAPS), state[15:1]};
        end
    end

    assign lsb = state[0];

endmodule

// File: rtl/udp_rx_checker.sv
// udp_rx_checker: checks received packets against the incrementing-counter test pattern and length.
// Define UDP_RX_CHECKER_STALL_EN to drive o_ready from an LFSR for read-side backpressure.
module udp_rx_checker
    import udp_test_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PKT_LEN      = 100,
    parameter int unsigned CHECK_ACROSS = 1
) (
    input  logic              i_Sys_clk,
    input  logic              i_Rst_n,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic [31:0]       o_pkt_cnt,
    output logic [15:0]       o_err_cnt,
    output logic              o_data_err,
    output logic              o_len_err,
    output logic [CNT_W-1:0]  o_last_len,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);

    chk_state_t        state, next_state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] last_data;
    logic              seq_valid;

    logic              xfer;
    logic              mismatch;
    logic              len_bad;
    logic              pkt_bad;
    logic [CNT_W-1:0]  end_len;

`ifdef UDP_RX_CHECKER_STALL_EN
    lfsr16 #(
        .SEED(LFSR_SEED),
        .TAPS(LFSR_TAPS)
    ) u_lfsr (
        .clk  (i_Sys_clk),
        .rst_n(i_Rst_n),
        .lsb  (o_ready)
    );
`else
    assign o_ready = 1'b1;
`endif

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (i_clr) begin
            next_state = IDLE;
        end else if (xfer) begin
            if (i_last) begin
                next_state = IDLE;
            end else if (mismatch) begin
                next_state = BAD;
            end else if (state == IDLE) begin
                next_state = RUN;
            end
        end
    end

    // Per-beat decode; BAD skips data checks but still tracks length.
    always_comb begin
        xfer     = i_valid && o_ready;
        mismatch = 1'b0;
        end_len  = sat_inc(beat_cnt);
        unique case (state)
            IDLE: begin
                mismatch = xfer && (CHECK_ACROSS != 0) && seq_valid &&
                           (i_data != last_data + DATA_W'(1));
                end_len  = CNT_W'(1);
            end
            RUN:     mismatch = xfer && (i_data != prev_data + DATA_W'(1));
            BAD:     mismatch = 1'b0;
            default: mismatch = 1'b0;
        endcase
        len_bad = (end_len != PKT_LEN_C);
        pkt_bad = mismatch || (state == BAD) || len_bad;
    end

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            beat_cnt   <= '0;
            prev_data  <= '0;
            last_data  <= '0;
            seq_valid  <= 1'b0;
            o_pkt_cnt  <= '0;
            o_err_cnt  <= '0;
            o_data_err <= 1'b0;
            o_len_err  <= 1'b0;
            o_last_len <= '0;
            o_busy     <= 1'b0;
        end else if (i_clr) begin
            beat_cnt   <= '0;
            seq_valid  <= 1'b0;
            o_pkt_cnt  <= '0;
            o_err_cnt  <= '0;
            o_data_err <= 1'b0;
            o_len_err  <= 1'b0;
            o_last_len <= '0;
            o_busy     <= 1'b0;
        end else begin
            o_data_err <= mismatch;
            o_len_err  <= xfer && i_last && len_bad;
            o_busy     <= (next_state != IDLE);
            if (xfer) begin
                prev_data <= i_data;
                beat_cnt  <= end_len;
                if (i_last) begin
                    o_last_len <= end_len;
                    last_data  <= i_data;
                    seq_valid  <= 1'b1;
                    if (pkt_bad) begin
                        if (o_err_cnt != '1) begin
                            o_err_cnt <= o_err_cnt + 16'd1;
                        end
                    end else begin
                        o_pkt_cnt <= o_pkt_cnt + 32'd1;
                    end
                end
            end
        end
    end

endmodule
